tagged_addr_buf: RTL and testbench

- Parametrised FIFO for in-flight memory request addresses, for use between the fetch/LSU address stage and the bus interface.
- Each entry carries data, a tag and a valid bit.
- Entries can be invalidated in place, either all at once by `flush` or selectively by tag via `kill`. Invalidated entries still occupy slots and drain in order with `valid`=0, so response ordering is preserved.
- Adds occupancy count and almost-full reporting.

---
 rtl/tagged_addr_buf.sv | 140 ++++++++++++++
 tb/tb_tagged_addr_buf.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/tagged_addr_buf.sv
// In-order FIFO of tagged request addresses with in-place invalidation (flush / kill-by-tag).
// Optional empty fall-through path enabled by defining TAGGED_ADDR_BUF_BYPASS_EN.
module tagged_addr_buf #(
  parameter int unsigned ADDR_WIDTH   = 4,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned TAG_WIDTH    = 2,
  parameter int unsigned AFULL_THRESH = 2**ADDR_WIDTH - 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  kill,
  input  logic [TAG_WIDTH-1:0]  kill_tag,
  input  logic                  wena,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [TAG_WIDTH-1:0]  wtag,
  input  logic                  rena,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [TAG_WIDTH-1:0]  rtag,
  output logic                  valid,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   count
);

  localparam int unsigned DEPTH = 2**ADDR_WIDTH;
  localparam int unsigned CNT_W = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [TAG_WIDTH-1:0]  tag_q  [DEPTH];
  logic [DEPTH-1:0]      vbit_q;
  logic [DEPTH-1:0]      vbit_d;
  logic [ADDR_WIDTH-1:0] rptr_q;
  logic [ADDR_WIDTH-1:0] wptr_q;
  logic [CNT_W-1:0]      count_q;
  logic [CNT_W-1:0]      count_d;
  logic                  empty_q;
  logic                  full_q;
  logic                  afull_q;
  logic                  bypass_c;
  logic                  pop_ok_c;
  logic                  push_ok_c;
  logic [TAG_WIDTH-1:0]  tag_nxt;

  // A push that is consumed straight through an empty buffer never touches storage.
`ifdef TAGGED_ADDR_BUF_BYPASS_EN
  assign bypass_c = empty_q && wena && rena;
`else
  assign bypass_c = 1'b0;
`endif

  assign pop_ok_c  = rena && !empty_q;
  assign push_ok_c = wena && (!full_q || pop_ok_c) && !bypass_c;

  // Occupancy moves only when exactly one of push/pop happens.
  always_comb begin
    count_d = count_q;
    case ({push_ok_c, pop_ok_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Kill compares against the post-write tag so a same-cycle matching push lands invalid.
  always_comb begin
    vbit_d  = vbit_q;
    tag_nxt = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (push_ok_c && (wptr_q == ADDR_WIDTH'(i))) begin
        tag_nxt = wtag;
      end else begin
        tag_nxt = tag_q[i];
      end
      if (flush) begin
        vbit_d[i] = 1'b0;
      end else if (kill && (tag_nxt == kill_tag)) begin
        vbit_d[i] = 1'b0;
      end else if (push_ok_c && (wptr_q == ADDR_WIDTH'(i))) begin
        vbit_d[i] = 1'b1;
      end else if (pop_ok_c && (rptr_q == ADDR_WIDTH'(i))) begin
        vbit_d[i] = 1'b0;
      end
    end
  end

  // Control state: pointers, count, status flags and valid bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      afull_q <= 1'b0;
      vbit_q  <= '0;
    end else begin
      if (pop_ok_c) begin
        rptr_q <= rptr_q + ADDR_WIDTH'(1);
      end
      if (push_ok_c) begin
        wptr_q <= wptr_q + ADDR_WIDTH'(1);
      end
      count_q <= count_d;
      empty_q <= (count_d == '0);
      full_q  <= (count_d == CNT_W'(DEPTH));
      afull_q <= (count_d >= CNT_W'(AFULL_THRESH));
      vbit_q  <= vbit_d;
    end
  end

  // Payload and tag storage carry no reset.
  always_ff @(posedge clk) begin
    if (!reset && push_ok_c) begin
      data_q[wptr_q] <= wdata;
      tag_q[wptr_q]  <= wtag;
    end
  end

  // Show-ahead head read.
  always_comb begin
    rdata = data_q[rptr_q];
    rtag  = tag_q[rptr_q];
    valid = vbit_q[rptr_q] && !empty_q;
`ifdef TAGGED_ADDR_BUF_BYPASS_EN
    if (empty_q && wena) begin
      rdata = wdata;
      rtag  = wtag;
      valid = !flush && !(kill && (wtag == kill_tag));
    end
`endif
  end

  assign empty       = empty_q;
  assign full        = full_q;
  assign almost_full = afull_q;
  assign count       = count_q;

endmodule

// File: tb/tb_tagged_addr_buf.sv
// Directed + random bench for tagged_addr_buf with a queue-based reference model.
module tb_tagged_addr_buf;

  localparam int unsigned AW = 2;
  localparam int unsigned DW = 32;
  localparam int unsigned TW = 2;
  localparam int unsigned AF = 3;
  localparam int unsigned DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic          kill;
  logic [TW-1:0] kill_tag;
  logic          wena;
  logic [DW-1:0] wdata;
  logic [TW-1:0] wtag;
  logic          rena;
  logic [DW-1:0] rdata;
  logic [TW-1:0] rtag;
  logic          valid;
  logic          empty;
  logic          full;
  logic          almost_full;
  logic [AW:0]   count;

  typedef struct {
    logic [DW-1:0] d;
    logic [TW-1:0] t;
    logic          v;
  } ent_t;

  ent_t q[$];
  int checks = 0;
  int errors = 0;

  tagged_addr_buf #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_WIDTH(TW), .AFULL_THRESH(AF)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush), .kill(kill), .kill_tag(kill_tag),
    .wena(wena), .wdata(wdata), .wtag(wtag), .rena(rena),
    .rdata(rdata), .rtag(rtag), .valid(valid), .empty(empty), .full(full),
    .almost_full(almost_full), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic check_status();
    chk("count", 32'(count), 32'(q.size()));
    chk("empty", 32'(empty), 32'(q.size() == 0));
    chk("full", 32'(full), 32'(q.size() == DEPTH));
    chk("almost_full", 32'(almost_full), 32'(q.size() >= AF));
  endtask

  // One clock of stimulus: check the head before the edge, update the model, check status after.
  task automatic step(input logic w, input logic [DW-1:0] wd, input logic [TW-1:0] wt,
                      input logic r, input logic fl, input logic kl, input logic [TW-1:0] kt);
    bit   pop_ok;
    bit   push_ok;
    bit   byp;
    logic nv;
    ent_t e;
    wena = w; wdata = wd; wtag = wt; rena = r; flush = fl; kill = kl; kill_tag = kt;
    #1;
    nv  = !fl && !(kl && (wt == kt));
    byp = 1'b0;
    if (q.size() > 0) begin
      chk("head_rdata", rdata, q[0].d);
      chk("head_rtag", 32'(rtag), 32'(q[0].t));
      chk("head_valid", 32'(valid), 32'(q[0].v));
    end else begin
`ifdef TAGGED_ADDR_BUF_BYPASS_EN
      if (w) begin
        chk("bypass_rdata", rdata, wd);
        chk("bypass_rtag", 32'(rtag), 32'(wt));
        chk("bypass_valid", 32'(valid), 32'(nv));
        byp = r;
      end else begin
        chk("empty_valid", 32'(valid), 32'h0);
      end
`else
      chk("empty_valid", 32'(valid), 32'h0);
`endif
    end
    pop_ok  = r && (q.size() > 0);
    push_ok = w && ((q.size() < DEPTH) || pop_ok) && !byp;
    if (pop_ok) void'(q.pop_front());
    foreach (q[i]) begin
      if (fl || (kl && (q[i].t == kt))) q[i].v = 1'b0;
    end
    if (push_ok) begin
      e.d = wd; e.t = wt; e.v = nv;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    check_status();
  endtask

  task automatic push(input logic [DW-1:0] d, input logic [TW-1:0] t);
    step(1'b1, d, t, 1'b0, 1'b0, 1'b0, 2'd0);
  endtask

  task automatic pop();
    step(1'b0, 32'h0, 2'd0, 1'b1, 1'b0, 1'b0, 2'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1; wena = 1'b1; rena = 1'b1; wdata = 32'hdead; wtag = 2'd0;
    flush = 1'b0; kill = 1'b0; kill_tag = 2'd0;
    @(posedge clk);
    #1;
    reset = 1'b0; wena = 1'b0; rena = 1'b0;
    q.delete();
    #1;
    check_status();
    chk("reset_valid", 32'(valid), 32'h0);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; kill = 1'b0; kill_tag = '0;
    wena = 1'b0; wdata = '0; wtag = '0; rena = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // Fill, overfill attempt, drain
    for (int i = 0; i < 4; i++) push(32'((i + 1) * 16), TW'(i));
    push(32'h99, 2'd0);
    for (int i = 0; i < 4; i++) pop();
    pop();

    // Wrap, then push+pop on full
    push(32'h10, 2'd0); push(32'h20, 2'd1); push(32'h30, 2'd2);
    pop(); pop();
    push(32'h50, 2'd3); push(32'h60, 2'd0); push(32'h70, 2'd1);
    step(1'b1, 32'h55, 2'd2, 1'b1, 1'b0, 1'b0, 2'd0);
    for (int i = 0; i < 4; i++) pop();

    // Pop+push at count 1
    push(32'h81, 2'd1);
    step(1'b1, 32'h82, 2'd2, 1'b1, 1'b0, 1'b0, 2'd0);
    pop();

    // Kill with same-cycle matching push
    push(32'ha1, 2'd1); push(32'ha2, 2'd2); push(32'ha3, 2'd1);
    step(1'b1, 32'ha4, 2'd1, 1'b0, 1'b0, 1'b1, 2'd1);
    for (int i = 0; i < 4; i++) pop();

    // Flush with push, then a clean push
    push(32'hb1, 2'd0); push(32'hb2, 2'd1); push(32'hb3, 2'd2);
    step(1'b1, 32'hb4, 2'd3, 1'b0, 1'b1, 1'b0, 2'd0);
    for (int i = 0; i < 4; i++) pop();
    push(32'hb5, 2'd0);
    pop();

    // Flush and kill alongside pops
    push(32'hc1, 2'd0); push(32'hc2, 2'd3); push(32'hc3, 2'd0);
    step(1'b0, 32'h0, 2'd0, 1'b1, 1'b0, 1'b1, 2'd0);
    step(1'b0, 32'h0, 2'd0, 1'b1, 1'b1, 1'b0, 2'd0);
    pop();

    // Reset mid-operation
    push(32'hd1, 2'd0); push(32'hd2, 2'd1); push(32'hd3, 2'd2);
    do_reset();

    // Empty with simultaneous push+pop (fall-through when bypass is built in)
    step(1'b1, 32'h77, 2'd1, 1'b1, 1'b0, 1'b0, 2'd0);
    pop();
    step(1'b1, 32'h78, 2'd1, 1'b1, 1'b0, 1'b1, 2'd1);
    pop();

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      step(1'($urandom_range(0, 1)), $urandom, TW'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 19) == 0),
           1'($urandom_range(0, 9) == 0), TW'($urandom_range(0, 3)));
    end
    for (int n = 0; n < 5; n++) pop();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
